float_contract_sched: RTL and testbench
=======================================

Name: float_contract_sched

Overview:
- Shares one FloatContract → FloatRoundToNearestEven conversion datapath (IN_EXP/IN_FRAC to OUT_EXP/OUT_FRAC) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every port, two-stage pipeline, each result tagged with the requester index.
- Sits between the vector lanes' wide-float outputs and the narrow-float writeback path.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- IN_EXP, 8, input exponent width.
- IN_FRAC, 23, input fraction width.
- OUT_EXP, 4, output exponent width.
- OUT_FRAC, 3, output fraction width.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  NUM_REQ  per-requester request valid.
- inReady  out  NUM_REQ  per-requester accept; at most one bit high.
- inData  in  NUM_REQ*(1+IN_EXP+IN_FRAC)  flattened input floats; requester i occupies slice i.
- outValid  out  1  result valid.
- outReady  in  1  downstream accept.
- outData  out  1+OUT_EXP+OUT_FRAC  rounded result.
- outId  out  IDW  requester index of outData; IDW = max(1, $clog2(NUM_REQ)).
- outIsNan  out  1  contract stage flagged NaN.

Behaviour:
- Reset values:
  - all valid bits 0; inReady 0.
  - outData, outId, outIsNan 0.
  - round-robin pointer 0.
- Stage S1 register: {valid, data, id}. Loaded on input handshake.
- Stage S2 register: {valid, rounded data, id, isNan}. Contract+round logic is combinational between S1 and S2; S2 drives the out* ports directly.
- Pipeline flow:
  - s2Adv = !s2Valid || outReady.
  - s1Adv = !s1Valid || (s1Valid && s2Adv).
- Arbiter:
  - grant = first index g ≥ ptr with inValid[g], searching with wrap modulo NUM_REQ.
  - inReady[g] = s1Adv && any(inValid); all other inReady bits are 0.
  - inReady is independent of inValid for non-granted lanes.
- Handshake:
  - On inValid[g] && inReady[g]: S1 loads lane g; ptr ← (g+1) mod NUM_REQ.
  - ptr holds if no handshake occurs.
- Latency: accept in cycle t → outValid in cycle t+2 when not stalled. Full throughput is 1 result/cycle.
- Backpressure:
  - outValid && !outReady holds S2 and all out* ports stable.
  - S1 holds when S2 is held and S1 is full; inReady is then all 0.
  - No data is lost or duplicated.
- Simultaneous events: S2 drain and S1→S2 move happen in the same cycle, as do an S1 load and an S1→S2 move.
- Fairness: any continuously asserted requester is granted within NUM_REQ accepts.
- Requester rule: inData[i] must stay stable while inValid[i] is high and unaccepted; the requester must not drop inValid before accept.
- Reset mid-operation: clears all valid bits and ptr next edge; in-flight results are discarded.
- Arithmetic: bit-exact with the standalone contract → round-to-nearest-even path, TRAILING_BITS=2, ties to even. NaN input → outIsNan=1 and NaN output encoding.

Optional Feature:
- Macro: FLOAT_CONTRACT_SCHED_STATS_EN.
- With the macro defined, extra output ports:
  - convCount [31:0]: increments on every out handshake.
  - nanCount [31:0]: increments on out handshakes with outIsNan.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package float_sched_pkg holds:
  - the IDW function;
  - a packed struct for the S2 payload {data, id, isNan};
  - localparam widths IN_W=1+IN_EXP+IN_FRAC, OUT_W=1+OUT_EXP+OUT_FRAC.
- One sub-module: rr_arbiter (NUM_REQ requests in; one-hot grant and encoded index out; ptr update on an advance strobe). It is reusable by other shared float units.
- The conversion datapath instantiates the existing FloatContract and FloatRoundToNearestEven unmodified.

Test Plan:
- Single request, lane 2, inData 32'h3EB504D7 (0.35355), outReady=1 → outValid exactly 2 cycles after accept; outData 8'h2B, outId 2, outIsNan 0.
- Rounding ties:
  - lane 0 sends 32'h3F880000 (1.0625) → 8'h38.
  - next lane 0 sends 32'h3F980000 (1.1875) → 8'h3A.
- All 4 lanes continuously valid with 1.0 (32'h3F800000), outReady=1 → outId sequence 0,1,2,3,0,…, 1 result/cycle, every outData 8'h38.
- Backpressure: outReady=0 for 5 cycles with 4 lanes valid →
  - at most 2 accepts, then inReady all 0;
  - out* stable while stalled;
  - after release, results arrive in accept order with no loss.
- NaN: lane 1 sends 32'h7FC00000 → outIsNan=1, outId 1. With FLOAT_CONTRACT_SCHED_STATS_EN, nanCount goes 0→1 and convCount 0→1.
- Reset asserted for 1 cycle with S1 and S2 full → next cycle outValid=0, inReady all 0 during reset, and ptr=0, so lane 0 wins the first grant afterward.

Source files
------------

// File: rtl/float_sched_pkg.sv
// Shared types and widths for the shared float contract/round scheduler.
// The payload struct is sized for the default configuration below.
package float_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_IN_EXP    = 8;
  localparam int DEF_IN_FRAC   = 23;
  localparam int DEF_OUT_EXP   = 4;
  localparam int DEF_OUT_FRAC  = 3;
  localparam int TRAILING_BITS = 2;

  localparam int IN_W  = 1 + DEF_IN_EXP + DEF_IN_FRAC;
  localparam int OUT_W = 1 + DEF_OUT_EXP + DEF_OUT_FRAC;

  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = idw(DEF_NUM_REQ);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [ID_W-1:0]  id;
    logic             isNan;
  } s2PayloadT;

endpackage

// File: rtl/FloatContract.sv
// Narrows a wide float to the target exponent range, keeping OUT_FRAC bits
// plus a guard bit and a sticky bit; flags NaN/Inf/zero (subnormals flush).
module FloatContract #(
  parameter int IN_EXP        = 8,
  parameter int IN_FRAC       = 23,
  parameter int OUT_EXP       = 4,
  parameter int OUT_FRAC      = 3,
  parameter int TRAILING_BITS = 2
) (
  input  logic [IN_EXP+IN_FRAC:0]           inFloat,
  output logic                              sign,
  output logic [OUT_EXP-1:0]                exp,
  output logic [OUT_FRAC+TRAILING_BITS-1:0] frac,
  output logic                              isNan,
  output logic                              isInf,
  output logic                              isZero
);

  localparam int IN_BIAS  = (1 << (IN_EXP - 1)) - 1;
  localparam int OUT_BIAS = (1 << (OUT_EXP - 1)) - 1;
  localparam int OUT_EMAX = (1 << OUT_EXP) - 1;
  localparam int KEEP     = OUT_FRAC + TRAILING_BITS - 1;
  localparam int DROP     = IN_FRAC - KEEP;

  logic [IN_EXP-1:0]  inExp;
  logic [IN_FRAC-1:0] inFrac;
  int                 rebased;

  always_comb begin
    sign    = inFloat[IN_EXP+IN_FRAC];
    inExp   = inFloat[IN_FRAC +: IN_EXP];
    inFrac  = inFloat[IN_FRAC-1:0];
    rebased = int'(inExp) - IN_BIAS + OUT_BIAS;
    isNan   = (&inExp) && (|inFrac);
    isInf   = 1'b0;
    isZero  = 1'b0;
    exp     = '0;
    frac    = '0;
    if (&inExp) begin
      isInf = !isNan;
    end else if (rebased >= OUT_EMAX) begin
      isInf = 1'b1;
    end else if (rebased <= 0) begin
      isZero = 1'b1;
    end else begin
      exp  = rebased[OUT_EXP-1:0];
      frac = {inFrac[IN_FRAC-1 -: KEEP], |inFrac[DROP-1:0]};
    end
  end

endmodule

// File: rtl/FloatRoundToNearestEven.sv
// Rounds a contracted float to OUT_FRAC bits, ties to even; a mantissa carry
// ripples into the exponent and naturally saturates to infinity.
module FloatRoundToNearestEven #(
  parameter int OUT_EXP       = 4,
  parameter int OUT_FRAC      = 3,
  parameter int TRAILING_BITS = 2
) (
  input  logic                              sign,
  input  logic [OUT_EXP-1:0]                exp,
  input  logic [OUT_FRAC+TRAILING_BITS-1:0] frac,
  input  logic                              isNan,
  input  logic                              isInf,
  input  logic                              isZero,
  output logic [OUT_EXP+OUT_FRAC:0]         outFloat
);

  logic [OUT_FRAC-1:0]         keep;
  logic                        half;
  logic                        rest;
  logic                        roundUp;
  logic [OUT_EXP+OUT_FRAC-1:0] mag;

  always_comb begin
    keep    = frac[TRAILING_BITS +: OUT_FRAC];
    half    = frac[TRAILING_BITS-1];
    rest    = |frac[TRAILING_BITS-2:0];
    roundUp = half && (rest || keep[0]);
    mag     = {exp, keep} + {{(OUT_EXP+OUT_FRAC-1){1'b0}}, roundUp};
    if (isNan) begin
      outFloat = {1'b0, {OUT_EXP{1'b1}}, 1'b1, {(OUT_FRAC-1){1'b0}}};
    end else if (isInf) begin
      outFloat = {sign, {OUT_EXP{1'b1}}, {OUT_FRAC{1'b0}}};
    end else if (isZero) begin
      outFloat = {sign, {(OUT_EXP+OUT_FRAC){1'b0}}};
    end else begin
      outFloat = {sign, mag};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping; the pointer moves past the winner only when advance is strobed.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grantIdx,
  output logic               anyReq
);

  logic [IDW-1:0] ptrReg;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grantIdx = '0;
    anyReq   = |req;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptrReg) + off) % NUM_REQ;
      if (req[idx]) grantIdx = IDW'(idx);
    end
    if (anyReq) grant[grantIdx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptrReg <= '0;
    end else if (advance) begin
      ptrReg <= (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/float_contract_sched.sv
// Round-robin shared float contract + round-to-nearest-even unit, two stages.
// Define FLOAT_CONTRACT_SCHED_STATS_EN to add saturating convCount/nanCount ports.
module float_contract_sched
  import float_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int IN_EXP   = DEF_IN_EXP,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_EXP  = DEF_OUT_EXP,
  parameter int OUT_FRAC = DEF_OUT_FRAC,
  localparam int IDW     = idw(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      inValid,
  output logic [NUM_REQ-1:0]      inReady,
  input  logic [NUM_REQ*IN_W-1:0] inData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [OUT_W-1:0]        outData,
  output logic [IDW-1:0]          outId,
  output logic                    outIsNan
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
  ,
  output logic [31:0]             convCount,
  output logic [31:0]             nanCount
`endif
);

  logic [IN_W-1:0]    laneData [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grantIdx;
  logic               anyReq;
  logic               accept;
  logic               s1Adv;
  logic               s2Adv;

  logic               s1Valid;
  logic [IN_W-1:0]    s1Data;
  logic [IDW-1:0]     s1Id;
  logic               s2Valid;
  s2PayloadT          s2Reg;

  logic                            cSign, cNan, cInf, cZero;
  logic [OUT_EXP-1:0]              cExp;
  logic [OUT_FRAC+TRAILING_BITS-1:0] cFrac;
  logic [OUT_W-1:0]                rounded;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gLane
      assign laneData[gi] = inData[gi*IN_W +: IN_W];
    end
  endgenerate

  assign s2Adv   = !s2Valid || outReady;
  assign s1Adv   = !s1Valid || s2Adv;
  // Reset gating keeps inReady low while reset is held, not just after it.
  assign accept  = s1Adv && anyReq && !reset;
  assign inReady = accept ? grant : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) uArb (
    .clock    (clock),
    .reset    (reset),
    .req      (inValid),
    .advance  (accept),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyReq   (anyReq)
  );

  FloatContract #(
    .IN_EXP(IN_EXP), .IN_FRAC(IN_FRAC), .OUT_EXP(OUT_EXP),
    .OUT_FRAC(OUT_FRAC), .TRAILING_BITS(TRAILING_BITS)
  ) uContract (
    .inFloat(s1Data), .sign(cSign), .exp(cExp), .frac(cFrac),
    .isNan(cNan), .isInf(cInf), .isZero(cZero)
  );

  FloatRoundToNearestEven #(
    .OUT_EXP(OUT_EXP), .OUT_FRAC(OUT_FRAC), .TRAILING_BITS(TRAILING_BITS)
  ) uRound (
    .sign(cSign), .exp(cExp), .frac(cFrac), .isNan(cNan),
    .isInf(cInf), .isZero(cZero), .outFloat(rounded)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
      s1Id    <= '0;
    end else if (s1Adv) begin
      s1Valid <= accept;
      if (accept) begin
        s1Data <= laneData[grantIdx];
        s1Id   <= grantIdx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Reg   <= '0;
    end else if (s2Adv) begin
      s2Valid <= s1Valid;
      if (s1Valid) s2Reg <= '{data: rounded, id: s1Id, isNan: cNan};
    end
  end

  assign outValid = s2Valid;
  assign outData  = s2Reg.data;
  assign outId    = s2Reg.id;
  assign outIsNan = s2Reg.isNan;

`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      convCount <= '0;
      nanCount  <= '0;
    end else if (s2Valid && outReady) begin
      if (convCount != '1) convCount <= convCount + 1'b1;
      if (s2Reg.isNan && nanCount != '1) nanCount <= nanCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_float_contract_sched.sv
// Scoreboard bench for float_contract_sched: directed vectors, monitor pops
// expected results on every output handshake.
`timescale 1ns/1ps
module tb_float_contract_sched;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    inValid;
  logic [N-1:0]    inReady;
  logic [N*32-1:0] inData;
  logic            outValid;
  logic            outReady;
  logic [7:0]      outData;
  logic [1:0]      outId;
  logic            outIsNan;
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
  logic [31:0]     convCount;
  logic [31:0]     nanCount;
`endif

  float_contract_sched dut (
    .clock    (clock),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outId    (outId),
    .outIsNan (outIsNan)
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
    ,
    .convCount(convCount),
    .nanCount (nanCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
    logic       nan;
  } expT;

  expT         sbQ[$];
  int          accCycQ[$];
  int          hsNegQ[$];
  logic [31:0] laneQ [N][$];
  logic [N-1:0] acc = '0;
  int          compared = 0;
  int          mismatched = 0;
  int          negCount = 0;
  int          acceptsSeen = 0;
  bit          latChk = 1'b0;
  logic        prevStall = 1'b0;
  logic [7:0]  heldData;
  logic [1:0]  heldId;
  logic        heldNan;
  expT         popE;
  int          popLat;
  int          base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expectOut(input int id, input logic [7:0] d, input logic nan);
    sbQ.push_back({d, 2'(id), nan});
  endtask

  // One clock of stimulus: retire accepted lane items, present the next ones.
  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && laneQ[i].size() > 0) void'(laneQ[i].pop_front());
      inValid[i] = (laneQ[i].size() > 0);
      inData[i*32 +: 32] = inValid[i] ? laneQ[i][0] : 32'h0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sbQ.size() != 0 || inValid != '0) && n < 300) begin
      step();
      n++;
    end
    check({name, "_drained"}, sbQ.size(), 0);
    step();
    step();
  endtask

  always @(negedge clock) begin
    negCount++;
    acc = inValid & inReady;
    if (acc != '0) begin
      accCycQ.push_back(negCount);
      acceptsSeen++;
    end
    if (!reset) begin
      check("inReady_onehot", ($countones(inReady) <= 1), 1);
      if (prevStall) begin
        check("stall_valid", outValid, 1);
        check("stall_data", outData, heldData);
        check("stall_id", outId, heldId);
        check("stall_nan", outIsNan, heldNan);
      end
      if (outValid && outReady) begin
        hsNegQ.push_back(negCount);
        if (sbQ.size() == 0) begin
          check("unexpected_out_id", outId, 2'bxx);
        end else begin
          popE = sbQ.pop_front();
          check("outData", outData, popE.d);
          check("outId", outId, popE.id);
          check("outIsNan", outIsNan, popE.nan);
          if (accCycQ.size() > 0) begin
            popLat = accCycQ.pop_front();
            if (latChk) check("latency", negCount - popLat, 2);
          end
        end
      end
      prevStall = outValid && !outReady;
      heldData  = outData;
      heldId    = outId;
      heldNan   = outIsNan;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    outReady = 1'b1;
    inValid  = '0;
    inData   = '0;
    step();
    step();

    // Reset state, with lane 1 already requesting
    laneQ[1].push_back(32'h7FC00000);
    expectOut(1, 8'h7C, 1'b1);
    step();
    @(negedge clock);
    check("reset_outValid", outValid, 0);
    check("reset_outData", outData, 0);
    check("reset_outId", outId, 0);
    check("reset_outIsNan", outIsNan, 0);
    check("reset_inReady", inReady, 0);
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
    check("reset_convCount", convCount, 0);
    check("reset_nanCount", nanCount, 0);
`endif
    step();
    reset  = 1'b0;
    latChk = 1'b1;
    drain("nan");
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
    check("nan_convCount", convCount, 1);
    check("nan_nanCount", nanCount, 1);
`endif

    // Single request on lane 2
    laneQ[2].push_back(32'h3EB504D7);
    expectOut(2, 8'h2B, 1'b0);
    drain("single");

    // Rounding ties on lane 0
    laneQ[0].push_back(32'h3F880000);
    laneQ[0].push_back(32'h3F980000);
    expectOut(0, 8'h38, 1'b0);
    expectOut(0, 8'h3A, 1'b0);
    drain("ties");

    // All lanes continuously valid; pointer sits at 1 after the last grant to lane 0
    hsNegQ.delete();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) laneQ[i].push_back(32'h3F800000);
      for (int k = 1; k <= N; k++) expectOut(k % N, 8'h38, 1'b0);
    end
    drain("rr");
    check("rr_count", hsNegQ.size(), 12);
    if (hsNegQ.size() == 12) check("rr_throughput", hsNegQ[11] - hsNegQ[0], 11);

    // Backpressure from an empty pipeline
    outReady = 1'b0;
    latChk   = 1'b0;
    base     = acceptsSeen;
    laneQ[0].push_back(32'h3F800000); laneQ[0].push_back(32'h40000000);
    laneQ[1].push_back(32'h3F980000); laneQ[1].push_back(32'h3FC00000);
    laneQ[2].push_back(32'h3EB504D7); laneQ[2].push_back(32'hBF800000);
    laneQ[3].push_back(32'h3F880000); laneQ[3].push_back(32'h3F980000);
    expectOut(1, 8'h3A, 1'b0);
    expectOut(2, 8'h2B, 1'b0);
    expectOut(3, 8'h38, 1'b0);
    expectOut(0, 8'h38, 1'b0);
    expectOut(1, 8'h3C, 1'b0);
    expectOut(2, 8'hB8, 1'b0);
    expectOut(3, 8'h3A, 1'b0);
    expectOut(0, 8'h40, 1'b0);
    step();
    repeat (4) step();
    @(negedge clock);
    check("bp_accepts", acceptsSeen - base, 2);
    check("bp_inReady", inReady, 0);
    step();
    outReady = 1'b1;
    drain("bp");
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
    check("pre_reset_convCount", convCount, 24);
    check("pre_reset_nanCount", nanCount, 1);
`endif

    // Reset with both stages full; pointer is 3 before reset
    outReady = 1'b0;
    laneQ[1].push_back(32'h3F800000);
    laneQ[2].push_back(32'h3F800000);
    laneQ[3].push_back(32'h3F800000);
    step();
    repeat (3) step();
    reset = 1'b1;
    @(negedge clock);
    check("midreset_inReady", inReady, 0);
    for (int i = 0; i < N; i++) laneQ[i].delete();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("postreset_outValid", outValid, 0);
    sbQ.delete();
    accCycQ.delete();
    outReady = 1'b1;
    latChk   = 1'b1;
    laneQ[3].push_back(32'hBF800000);
    laneQ[0].push_back(32'h3FC00000);
    expectOut(0, 8'h3C, 1'b0);
    expectOut(3, 8'hB8, 1'b0);
    drain("postreset");
`ifdef FLOAT_CONTRACT_SCHED_STATS_EN
    check("end_convCount", convCount, 2);
    check("end_nanCount", nanCount, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
